// File: rtl/rr_arbiter_hs.sv
// Round-robin arbiter with a registered one-hot grant held until the consumer accepts it.
// Optional burst lock is enabled by defining RR_ARB_LOCK_EN.
module rr_arbiter_hs #(
  parameter int PORT  = 4,
  parameter int IDX_W = $clog2(PORT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PORT-1:0]  req,
  input  logic             ready,
  input  logic [PORT-1:0]  lock,
  output logic [PORT-1:0]  gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam logic [PORT-1:0] ONE  = PORT'(1);
  localparam logic [PORT-1:0] ONES = {PORT{1'b1}};

  logic [PORT-1:0]  gnt_q, gnt_d;
  logic [PORT-1:0]  mask_q, mask_d;
  logic [PORT-1:0]  mask_eff_s;
  logic [PORT-1:0]  masked_req_s;
  logic [IDX_W-1:0] idx_s;
  logic             valid_s;
  logic             acc_s;
  logic             lock_hold_s;

  function automatic logic [PORT-1:0] lowest_bit(input logic [PORT-1:0] v);
    return v & (~v + ONE);
  endfunction

  assign valid_s = |gnt_q;
  assign acc_s   = valid_s & ready;

`ifdef RR_ARB_LOCK_EN
  assign lock_hold_s = acc_s & (|(gnt_q & lock));
`else
  assign lock_hold_s = 1'b0 & (|(gnt_q & lock));
`endif

  // Bits above the granted index: ~(onehot | onehot-1); the top port wraps to an empty mask.
  always_comb begin
    if (acc_s) begin
      mask_eff_s = ~(gnt_q | (gnt_q - ONE));
    end else begin
      mask_eff_s = mask_q;
    end
  end

  assign masked_req_s = req & mask_eff_s;

  // Next-state: hold while stalled or locked, otherwise arbitrate over the rotated mask.
  always_comb begin
    gnt_d  = gnt_q;
    mask_d = mask_q;
    if (valid_s && !ready) begin
      gnt_d  = gnt_q;
      mask_d = mask_q;
    end else if (lock_hold_s) begin
      gnt_d  = gnt_q;
      mask_d = mask_q;
    end else begin
      mask_d = mask_eff_s;
      if (masked_req_s != '0) begin
        gnt_d = lowest_bit(masked_req_s);
      end else begin
        gnt_d = lowest_bit(req);
      end
    end
  end

  // Grant and priority mask registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q  <= '0;
      mask_q <= ONES;
    end else begin
      gnt_q  <= gnt_d;
      mask_q <= mask_d;
    end
  end

  // Binary index derived from the registered one-hot grant.
  always_comb begin
    idx_s = '0;
    for (int i = 0; i < PORT; i++) begin
      if (gnt_q[i]) begin
        idx_s = idx_s | IDX_W'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_s;
  assign gnt_idx   = idx_s;

endmodule

// File: tb/tb_rr_arbiter_hs.sv
// Directed scoreboard bench for rr_arbiter_hs (PORT=4); expected grants are queued per cycle
// by the driver and popped by a monitor on the falling edge.
module tb_rr_arbiter_hs;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       ready;
  logic [3:0] lock;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] idx;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  rr_arbiter_hs #(.PORT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ready     (ready),
    .lock      (lock),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare registered outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (gnt !== e.g || gnt_valid !== (|e.g) || gnt_idx !== e.idx) begin
        errors++;
        $display("FAIL grant: got gnt=%b valid=%b idx=%0d, expected gnt=%b valid=%b idx=%0d",
                 gnt, gnt_valid, gnt_idx, e.g, |e.g, e.idx);
      end
    end
  end

  // Apply inputs, clock one edge, queue the grant expected after that edge.
  task automatic step(input logic [3:0] r, input logic rdy, input logic [3:0] lk,
                      input logic [3:0] eg, input logic [1:0] ei);
    exp_t e;
    req   = r;
    ready = rdy;
    lock  = lk;
    @(posedge clk);
    e.g   = eg;
    e.idx = ei;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL %s: got gnt=%b valid=%b idx=%0d, expected all zero", name, gnt, gnt_valid, gnt_idx);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    ready = 1'b0;
    lock  = 4'b0000;

    // T1: reset with all requests pending
    #12;
    check_idle("reset_hold");
    @(posedge clk);
    #1;
    check_idle("reset_hold2");
    reset = 1'b0;

    // T2: full rotation with wrap-around
    step(4'b1111, 1'b1, 4'b0000, 4'b0001, 2'd0);
    step(4'b1111, 1'b1, 4'b0000, 4'b0010, 2'd1);
    step(4'b1111, 1'b1, 4'b0000, 4'b0100, 2'd2);
    step(4'b1111, 1'b1, 4'b0000, 4'b1000, 2'd3);
    step(4'b1111, 1'b1, 4'b0000, 4'b0001, 2'd0);
    step(4'b1111, 1'b1, 4'b0000, 4'b0010, 2'd1);
    step(4'b1111, 1'b1, 4'b0000, 4'b0100, 2'd2);
    step(4'b1111, 1'b1, 4'b0000, 4'b1000, 2'd3);

    // T3: sparse requests
    step(4'b1010, 1'b1, 4'b0000, 4'b0010, 2'd1);
    step(4'b1010, 1'b1, 4'b0000, 4'b1000, 2'd3);
    step(4'b1010, 1'b1, 4'b0000, 4'b0010, 2'd1);
    step(4'b1010, 1'b1, 4'b0000, 4'b1000, 2'd3);

    // T4: stall holds the grant, even with the request dropped
    step(4'b0011, 1'b1, 4'b0000, 4'b0001, 2'd0);
    step(4'b0011, 1'b0, 4'b0000, 4'b0001, 2'd0);
    step(4'b0000, 1'b0, 4'b0000, 4'b0001, 2'd0);
    step(4'b0011, 1'b0, 4'b0000, 4'b0001, 2'd0);
    step(4'b0011, 1'b1, 4'b0000, 4'b0010, 2'd1);

    // T5: burst lock
    step(4'b0011, 1'b1, 4'b0000, 4'b0001, 2'd0);
`ifdef RR_ARB_LOCK_EN
    step(4'b0011, 1'b1, 4'b0001, 4'b0001, 2'd0);
    step(4'b0011, 1'b1, 4'b0001, 4'b0001, 2'd0);
    step(4'b0011, 1'b1, 4'b0001, 4'b0001, 2'd0);
    step(4'b0011, 1'b1, 4'b0000, 4'b0010, 2'd1);
`else
    step(4'b0011, 1'b1, 4'b0001, 4'b0010, 2'd1);
    step(4'b0011, 1'b1, 4'b0001, 4'b0001, 2'd0);
    step(4'b0011, 1'b1, 4'b0001, 4'b0010, 2'd1);
    step(4'b0011, 1'b1, 4'b0000, 4'b0001, 2'd0);
    step(4'b0011, 1'b1, 4'b0000, 4'b0010, 2'd1);
`endif

    // ready while idle must not disturb the mask left by the last accept (port 1)
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0);
    step(4'b1001, 1'b1, 4'b0000, 4'b1000, 2'd3);

    // sole requester wins back-to-back
    step(4'b0100, 1'b1, 4'b0000, 4'b0100, 2'd2);
    step(4'b0100, 1'b1, 4'b0000, 4'b0100, 2'd2);

    // T6: reset while port 2 holds the grant
    step(4'b1111, 1'b0, 4'b0000, 4'b0100, 2'd2);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_idle("midop_reset");
    @(posedge clk);
    #1;
    check_idle("midop_reset_edge");
    reset = 1'b0;
    step(4'b1111, 1'b1, 4'b0000, 4'b0001, 2'd0);
    step(4'b1111, 1'b1, 4'b0000, 4'b0010, 2'd1);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
